// File: rtl/snn_tile_streamer.sv
// Tile buffer and start/stream sequencer feeding the SNN core input port.
// Loads IMAGE_WIDTH^2 pixels, then on go emits start, one gap cycle, the raster stream and a flush tail.
module snn_tile_streamer #(
  parameter int unsigned IMAGE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TAIL_CYCLES = 26
) (
  input  logic                                         iClk,
  input  logic                                         iRst,
  input  logic [DATA_WIDTH-1:0]                        iWrData,
  input  logic                                         iWrValid,
  output logic                                         oWrReady,
  input  logic                                         iGo,
  output logic                                         oStart,
  output logic [DATA_WIDTH-1:0]                        oData,
  output logic                                         oValid,
  output logic                                         oBusy,
  output logic                                         oDone,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_WIDTH):0]     oLevel
);

  localparam int unsigned PIXEL_COUNT = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int unsigned ADDR_W      = $clog2(PIXEL_COUNT);
  localparam int unsigned LEVEL_W     = ADDR_W + 1;
  localparam int unsigned TAIL_W      = $clog2(TAIL_CYCLES);

  typedef enum logic [2:0] {
    S_LOAD, S_FULL, S_START, S_GAP, S_STREAM, S_TAIL
  } state_t;

  state_t                  state_q, state_d;
  logic [LEVEL_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]       rd_cnt_q, rd_cnt_d, rd_next;
  logic [TAIL_W-1:0]       tail_cnt_q, tail_cnt_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    start_q, start_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [PIXEL_COUNT];

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    tail_cnt_d = tail_cnt_q;
    wr_ready_d = 1'b0;
    start_d    = 1'b0;
    valid_d    = 1'b0;
    data_d     = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    rd_next    = rd_cnt_q + 1'b1;
    case (state_q)
      S_LOAD: begin
        wr_ready_d = 1'b1;
        if (iWrValid && wr_ready_q && (wr_cnt_q != LEVEL_W'(PIXEL_COUNT))) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LEVEL_W'(PIXEL_COUNT - 1)) begin
            state_d    = S_FULL;
            wr_ready_d = 1'b0;
          end
        end
      end
      S_FULL: begin
        if (iGo) begin
          state_d = S_START;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        state_d  = S_GAP;
        rd_cnt_d = '0;
      end
      // Output flops lead the state by one cycle, so the first pixel is fetched while in GAP.
      S_GAP: begin
        state_d = S_STREAM;
        valid_d = 1'b1;
        data_d  = mem_q[rd_cnt_q];
      end
      S_STREAM: begin
        if (rd_cnt_q == ADDR_W'(PIXEL_COUNT - 1)) begin
          state_d    = S_TAIL;
          tail_cnt_d = '0;
        end else begin
          valid_d  = 1'b1;
          rd_cnt_d = rd_next;
          data_d   = mem_q[rd_next];
        end
      end
      S_TAIL: begin
        tail_cnt_d = tail_cnt_q + 1'b1;
        if (tail_cnt_q == TAIL_W'(TAIL_CYCLES - 2)) begin
          done_d   = 1'b1;
          wr_cnt_d = '0;
        end
        if (tail_cnt_q == TAIL_W'(TAIL_CYCLES - 1)) begin
          state_d    = S_LOAD;
          wr_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= S_LOAD;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tail_cnt_q <= '0;
      wr_ready_q <= 1'b1;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      wr_ready_q <= wr_ready_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (mem_we) mem_q[wr_cnt_q[ADDR_W-1:0]] <= iWrData;
  end

  assign oWrReady = wr_ready_q;
  assign oStart   = start_q;
  assign oData    = data_q;
  assign oValid   = valid_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oLevel   = wr_cnt_q;

endmodule

// File: tb/tb_snn_tile_streamer.sv
// Scoreboard bench: stimulus pushes expected pulses/pixels with their cycle; a negedge monitor pops and compares.
module tb_snn_tile_streamer;
  localparam int PC = 256;
  localparam int TC = 26;
  localparam int LOADP = 0, FULLP = 1, BUSYP = 2;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic [7:0] iWrData = '0;
  logic       iWrValid = 1'b0;
  logic       iGo = 1'b0;
  logic       oWrReady, oStart, oValid, oBusy, oDone;
  logic [7:0] oData;
  logic [8:0] oLevel;

  snn_tile_streamer #(.IMAGE_WIDTH(16), .DATA_WIDTH(8), .TAIL_CYCLES(TC)) dut (
    .iClk(iClk), .iRst(iRst), .iWrData(iWrData), .iWrValid(iWrValid), .oWrReady(oWrReady),
    .iGo(iGo), .oStart(oStart), .oData(oData), .oValid(oValid), .oBusy(oBusy),
    .oDone(oDone), .oLevel(oLevel)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { int cyc; logic [7:0] d; } pix_t;
  pix_t pix_q[$];
  int   start_q[$];
  int   done_q[$];
  int   busy_lo = 1, busy_hi = 0;

  // Reference model: tile contents, loaded count, coarse phase, end of current busy window.
  logic [7:0] ref_mem [PC];
  int lvl = 0, ph = LOADP, done_cyc = 0, last_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  pix_t mp;
  always @(negedge iClk) begin
    if (iRst) begin
      if (start_q.size() > 0 && start_q[0] == cyc) begin
        chk("start_pulse", int'(oStart), 1);
        void'(start_q.pop_front());
      end else chk("no_stray_start", int'(oStart), 0);
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
        mp = pix_q.pop_front();
        chk("stream_valid", int'(oValid), 1);
        chk("stream_data", int'(oData), int'(mp.d));
      end else begin
        chk("no_stray_valid", int'(oValid), 0);
        chk("idle_data_zero", int'(oData), 0);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        chk("done_pulse", int'(oDone), 1);
        void'(done_q.pop_front());
      end else chk("no_stray_done", int'(oDone), 0);
      chk("busy", int'(oBusy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  task automatic step(input bit wrv, input logic [7:0] wd, input bit go);
    int n;
    @(negedge iClk);
    #1;
    n = cyc;
    last_n = n;
    if (ph == BUSYP && n > done_cyc) begin
      ph = LOADP;
      lvl = 0;
    end
    if (ph != BUSYP) begin
      chk("wr_ready", int'(oWrReady), (ph == LOADP) ? 1 : 0);
      chk("level", int'(oLevel), lvl);
    end
    iWrValid = wrv;
    iWrData  = wd;
    iGo      = go;
    if (ph == LOADP && wrv) begin
      ref_mem[lvl] = wd;
      lvl++;
      if (lvl == PC) ph = FULLP;
    end else if (ph == FULLP && go) begin
      ph = BUSYP;
      start_q.push_back(n + 1);
      for (int k = 0; k < PC; k++) pix_q.push_back('{n + 3 + k, ref_mem[k]});
      done_cyc = n + 2 + PC + TC;
      done_q.push_back(done_cyc);
      busy_lo = n + 1;
      busy_hi = done_cyc;
    end
  endtask

  task automatic fill(input int mode, input logic [7:0] c, input int gap_pct, input bit go);
    int guard = 0;
    bit w;
    logic [7:0] d;
    while (ph != FULLP && guard < 3000) begin
      w = ($urandom_range(0, 99) >= gap_pct);
      case (mode)
        0:       d = lvl[7:0];
        1:       d = 8'((lvl * 7 + 3) & 255);
        2:       d = c;
        default: d = 8'($urandom);
      endcase
      step(w, d, go);
      guard++;
    end
    chk("fill_completes", ph, FULLP);
  endtask

  task automatic drain(input bit go);
    int g = 0;
    while (ph == BUSYP && g < 1000) begin
      step(1'b0, 8'h00, go);
      g++;
    end
    chk("stream_finishes", ph, LOADP);
    repeat (3) step(1'b0, 8'h00, go);
  endtask

  int g0;
  int guard;
  initial begin
    repeat (3) @(negedge iClk);
    #1;
    chk("rst_start", int'(oStart), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_data", int'(oData), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);
    chk("rst_level", int'(oLevel), 0);
    iRst = 1'b1;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Ramp fill with iWrValid held, writes during FULL must be dropped, then a single go pulse.
    fill(0, 8'h00, 0, 1'b0);
    repeat (5) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    drain(1'b0);

    // iGo held through the fill and well past the stream: exactly one burst.
    fill(3, 8'h00, 0, 1'b1);
    repeat (400) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("single_burst_consumed", pix_q.size() + start_q.size() + done_q.size(), 0);

    // Gapped writes with pattern (i*7+3)&0xFF.
    fill(1, 8'h00, 40, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    drain(1'b0);

    // Reset while pixel 100 is on the bus.
    fill(3, 8'h00, 20, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    g0 = last_n;
    guard = 0;
    while (last_n < g0 + 103 && guard < 200) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("reached_pixel_100", last_n, g0 + 103);
    iRst = 1'b0;
    #1;
    chk("midrst_valid", int'(oValid), 0);
    chk("midrst_data", int'(oData), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_done", int'(oDone), 0);
    pix_q.delete();
    start_q.delete();
    done_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    ph = LOADP;
    lvl = 0;
    iGo = 1'b0;
    iWrValid = 1'b0;
    repeat (2) @(negedge iClk);
    #1;
    iRst = 1'b1;
    repeat (220) step(1'b0, 8'h00, 1'b0);

    // Back-to-back tiles; the 0x55 refill keeps iWrValid high through the first stream.
    fill(2, 8'hAA, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    fill(2, 8'h55, 0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    drain(1'b0);

    chk("pixels_outstanding", pix_q.size(), 0);
    chk("starts_outstanding", start_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
